sar_logic: RTL and testbench

- Synchronous SAR controller for the differential monotonic-switching SAR ADC.
- Drives the two capacitor-DAC three-level controls (P and N side) and the sample switch.
- Consumes the comparator decision each cycle and produces the ADC_BITS-wide output code.
- Sits between the comparator model and the P/N capacitor DAC models; it is the control end of the DAC h/l interface.

---
 rtl/sar_pkg.sv | 25 ++
 rtl/sar_dac_switch.sv | 51 +++++
 rtl/sar_logic.sv | 230 +++++++++++++++++++++++
 tb/tb_sar_logic.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/sar_pkg.sv
// sar_pkg: shared types and helpers for the SAR controller.
//   sar_state_t   - controller FSM states (CAL only reachable with SAR_OFFSET_CAL_EN)
//   DAC_SEL_*     - {h,l} per-cap select codes for the three DAC levels
//   cap_index()   - cap (and result bit) index decided by conversion step k
package sar_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SAMPLE = 3'd1,
        CONV   = 3'd2,
        DONE   = 3'd3,
        CAL    = 3'd4
    } sar_state_t;

    // {h, l} pair per cap; 2'b11 is never driven
    localparam logic [1:0] DAC_SEL_VREFP = 2'b10;
    localparam logic [1:0] DAC_SEL_VREFN = 2'b01;
    localparam logic [1:0] DAC_SEL_VCM   = 2'b00;

    // Step k resolves result bit adc_bits-1-k and switches the cap with the same index
    function automatic int unsigned cap_index(input int unsigned adc_bits, input int unsigned k);
        return adc_bits - 1 - k;
    endfunction

endpackage

// File: rtl/sar_dac_switch.sv
// sar_dac_switch: one side's capacitor-DAC h/l register bank.
// Caps are indexed [ADC_BITS-1:1]. Priority: reset/preset-vrefp > preset-vcm > switch.
// Ports:
//   clk, rst         - clock, synchronous active-high reset (all caps to vrefp)
//   i_preset_vrefp   - load all caps with vrefp
//   i_preset_vcm     - load all caps with vcm
//   i_sw_en          - move cap i_sw_idx to vrefn
//   i_sw_idx         - cap index to switch
//   o_dac_h/o_dac_l  - registered per-cap high/low selects
module sar_dac_switch
    import sar_pkg::*;
#(
    parameter int unsigned ADC_BITS = 8,
    localparam int unsigned IDX_W   = $clog2(ADC_BITS)
)(
    input  logic                clk,
    input  logic                rst,
    input  logic                i_preset_vrefp,
    input  logic                i_preset_vcm,
    input  logic                i_sw_en,
    input  logic [IDX_W-1:0]    i_sw_idx,
    output logic [ADC_BITS-1:1] o_dac_h,
    output logic [ADC_BITS-1:1] o_dac_l
);

    logic [ADC_BITS-1:1] r_h;
    logic [ADC_BITS-1:1] r_l;

    // Per-cap bank; switching only ever moves a cap to vrefn
    always_ff @(posedge clk) begin
        if (rst || i_preset_vrefp) begin
            for (int i = 1; i < int'(ADC_BITS); i++) begin
                {r_h[i], r_l[i]} <= DAC_SEL_VREFP;
            end
        end else if (i_preset_vcm) begin
            for (int i = 1; i < int'(ADC_BITS); i++) begin
                {r_h[i], r_l[i]} <= DAC_SEL_VCM;
            end
        end else if (i_sw_en) begin
            for (int i = 1; i < int'(ADC_BITS); i++) begin
                if (IDX_W'(i) == i_sw_idx) begin
                    {r_h[i], r_l[i]} <= DAC_SEL_VREFN;
                end
            end
        end
    end

    assign o_dac_h = r_h;
    assign o_dac_l = r_l;

endmodule

// File: rtl/sar_logic.sv
// sar_logic: synchronous controller for a differential monotonic-switching SAR ADC.
// Samples, runs ADC_BITS comparator steps driving the P/N capacitor DACs, emits the code.
// Optional offset calibration is enabled by defining SAR_OFFSET_CAL_EN.
// Ports:
//   clk, rst        - clock, synchronous active-high reset
//   start           - conversion request (IDLE only)
//   cal_req         - calibration request, priority over start (SAR_OFFSET_CAL_EN)
//   comp_p          - comparator decision, 1 = P side above N side
//   sample          - sample switch enable
//   comp_en         - comparator enable
//   dac_data_{h,l}_{p,n} - per-cap DAC selects [ADC_BITS-1:1]
//   dout, valid     - result code and its one-cycle strobe
//   cal_offset      - signed comparator offset estimate (SAR_OFFSET_CAL_EN)
//   busy            - controller not in IDLE
module sar_logic
    import sar_pkg::*;
#(
    parameter int unsigned ADC_BITS      = 8,
    parameter int unsigned SAMPLE_CYCLES = 2,
    parameter int unsigned CAL_CYCLES    = 16
)(
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
`ifdef SAR_OFFSET_CAL_EN
    input  logic                          cal_req,
    output logic signed [$clog2(CAL_CYCLES):0] cal_offset,
`endif
    input  logic                          comp_p,
    output logic                          sample,
    output logic                          comp_en,
    output logic [ADC_BITS-1:1]           dac_data_h_p,
    output logic [ADC_BITS-1:1]           dac_data_l_p,
    output logic [ADC_BITS-1:1]           dac_data_h_n,
    output logic [ADC_BITS-1:1]           dac_data_l_n,
    output logic [ADC_BITS-1:0]           dout,
    output logic                          valid,
    output logic                          busy
);

    localparam int unsigned CNT_MAX_A = (SAMPLE_CYCLES > ADC_BITS) ? SAMPLE_CYCLES : ADC_BITS;
    localparam int unsigned CNT_MAX   = (CAL_CYCLES > CNT_MAX_A) ? CAL_CYCLES : CNT_MAX_A;
    localparam int unsigned CNT_W     = $clog2(CNT_MAX);
    localparam int unsigned IDX_W     = $clog2(ADC_BITS);
`ifdef SAR_OFFSET_CAL_EN
    localparam int unsigned CAL_W     = $clog2(CAL_CYCLES) + 1;
`endif

    sar_state_t          r_state;
    sar_state_t          w_state_nxt;
    logic [CNT_W-1:0]    r_cnt;
    logic [CNT_W-1:0]    w_cnt_nxt;
    logic [ADC_BITS-1:0] r_result;
    logic [ADC_BITS-1:0] w_result_nxt;
    logic [ADC_BITS-1:0] r_dout;
    logic [ADC_BITS-1:0] w_dout_nxt;
    logic                r_sample;
    logic                r_comp_en;
    logic                r_valid;
    logic                r_busy;

    logic                w_comp;
    logic                w_preset_vrefp;
    logic                w_preset_vcm;
    logic                w_sw_p;
    logic                w_sw_n;
    logic [IDX_W-1:0]    w_sw_idx;

`ifdef SAR_OFFSET_CAL_EN
    logic [CAL_W-1:0]    r_ones;
    logic [CAL_W-1:0]    w_ones_nxt;
    logic [CAL_W-1:0]    r_offset;
    logic [CAL_W-1:0]    w_offset_nxt;
`endif

    // Unknown comparator output must count as 0: an X condition takes the default
    always_comb begin
        w_comp = 1'b0;
        if (comp_p) begin
            w_comp = 1'b1;
        end
    end

    a_comp_known : assert property (@(posedge clk) disable iff (rst)
                                    (r_state == CONV) |-> !$isunknown(comp_p))
        else $error("sar_logic: comp_p unknown during conversion");

    // Next-state, counter, result and DAC control decode
    always_comb begin
        w_state_nxt    = r_state;
        w_cnt_nxt      = r_cnt;
        w_result_nxt   = r_result;
        w_dout_nxt     = r_dout;
        w_preset_vrefp = 1'b0;
        w_preset_vcm   = 1'b0;
        w_sw_p         = 1'b0;
        w_sw_n         = 1'b0;
        w_sw_idx       = IDX_W'(cap_index(ADC_BITS, 32'(r_cnt)));
`ifdef SAR_OFFSET_CAL_EN
        w_ones_nxt     = r_ones;
        w_offset_nxt   = r_offset;
`endif
        case (r_state)
            IDLE: begin
                w_preset_vrefp = 1'b1;
`ifdef SAR_OFFSET_CAL_EN
                if (cal_req) begin
                    w_state_nxt    = CAL;
                    w_cnt_nxt      = '0;
                    w_ones_nxt     = '0;
                    w_preset_vrefp = 1'b0;
                    w_preset_vcm   = 1'b1;
                end else
`endif
                if (start) begin
                    w_state_nxt = SAMPLE;
                    w_cnt_nxt   = '0;
                end
            end
            SAMPLE: begin
                w_preset_vrefp = 1'b1;
                if (r_cnt == CNT_W'(SAMPLE_CYCLES - 1)) begin
                    w_state_nxt  = CONV;
                    w_cnt_nxt    = '0;
                    w_result_nxt = '0;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            CONV: begin
                // Result bit and switched cap share the step's index
                w_result_nxt = r_result | (ADC_BITS'(w_comp) << w_sw_idx);
                if (r_cnt == CNT_W'(ADC_BITS - 1)) begin
                    w_state_nxt = DONE;
                    w_dout_nxt  = w_result_nxt;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                    w_sw_p    = w_comp;
                    w_sw_n    = !w_comp;
                end
            end
            DONE: begin
                w_preset_vrefp = 1'b1;
                w_state_nxt    = IDLE;
            end
`ifdef SAR_OFFSET_CAL_EN
            CAL: begin
                // DACs hold vcm from entry; count ones over the window
                w_ones_nxt = r_ones + CAL_W'(w_comp);
                if (r_cnt == CNT_W'(CAL_CYCLES - 1)) begin
                    w_state_nxt  = DONE;
                    w_offset_nxt = w_ones_nxt - CAL_W'(CAL_CYCLES / 2);
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
`endif
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // State and registered outputs; flags follow the state being entered
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_result  <= '0;
            r_dout    <= '0;
            r_sample  <= 1'b0;
            r_comp_en <= 1'b0;
            r_valid   <= 1'b0;
            r_busy    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_result  <= w_result_nxt;
            r_dout    <= w_dout_nxt;
            r_sample  <= (w_state_nxt == SAMPLE);
            r_comp_en <= (w_state_nxt == CONV) || (w_state_nxt == CAL);
            r_valid   <= (w_state_nxt == DONE);
            r_busy    <= (w_state_nxt != IDLE);
        end
    end

`ifdef SAR_OFFSET_CAL_EN
    // Calibration accumulator and result
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ones   <= '0;
            r_offset <= '0;
        end else begin
            r_ones   <= w_ones_nxt;
            r_offset <= w_offset_nxt;
        end
    end

    assign cal_offset = $signed(r_offset);
`endif

    sar_dac_switch #(.ADC_BITS(ADC_BITS)) u_dac_p (
        .clk            (clk),
        .rst            (rst),
        .i_preset_vrefp (w_preset_vrefp),
        .i_preset_vcm   (w_preset_vcm),
        .i_sw_en        (w_sw_p),
        .i_sw_idx       (w_sw_idx),
        .o_dac_h        (dac_data_h_p),
        .o_dac_l        (dac_data_l_p)
    );

    sar_dac_switch #(.ADC_BITS(ADC_BITS)) u_dac_n (
        .clk            (clk),
        .rst            (rst),
        .i_preset_vrefp (w_preset_vrefp),
        .i_preset_vcm   (w_preset_vcm),
        .i_sw_en        (w_sw_n),
        .i_sw_idx       (w_sw_idx),
        .o_dac_h        (dac_data_h_n),
        .o_dac_l        (dac_data_l_n)
    );

    assign sample  = r_sample;
    assign comp_en = r_comp_en;
    assign dout    = r_dout;
    assign valid   = r_valid;
    assign busy    = r_busy;

endmodule

// File: tb/tb_sar_logic.sv
// tb_sar_logic: randomized scoreboard bench for sar_logic (ADC_BITS=8, SAMPLE_CYCLES=2).
// Stimulus queues one expected conversion per start; a negedge monitor derives the
// expected controls, DAC levels and code from the conversion's cycle position.
// With SAR_OFFSET_CAL_EN defined, a calibration run is also exercised.
module tb_sar_logic;

    localparam int B = 8;
    localparam int S = 2;
    localparam int C = 16;

    logic clk    = 1'b0;
    logic rst    = 1'b1;
    logic start  = 1'b0;
    logic comp_p = 1'b0;
    logic sample;
    logic comp_en;
    logic valid;
    logic busy;
    logic [B-1:1] hp, lp, hn, ln;
    logic [B-1:0] dout;
`ifdef SAR_OFFSET_CAL_EN
    logic cal_req = 1'b0;
    logic signed [$clog2(C):0] cal_offset;
`endif

    bit          cal_active = 1'b0;
    int unsigned cyc        = 0;
    bit          rst_d      = 1'b1;
    int          checks     = 0;
    int          errors     = 0;
    logic [B-1:0] exp_dout  = '0;

    typedef struct {
        logic [B-1:0] pat;
        int unsigned  e0;
    } item_t;
    item_t q[$];

    sar_logic #(.ADC_BITS(B), .SAMPLE_CYCLES(S), .CAL_CYCLES(C)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
`ifdef SAR_OFFSET_CAL_EN
        .cal_req      (cal_req),
        .cal_offset   (cal_offset),
`endif
        .comp_p       (comp_p),
        .sample       (sample),
        .comp_en      (comp_en),
        .dac_data_h_p (hp),
        .dac_data_l_p (lp),
        .dac_data_h_n (hn),
        .dac_data_l_n (ln),
        .dout         (dout),
        .valid        (valid),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc   <= cyc + 1;
        rst_d <= rst;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0h, want %0h", name, cyc, act, exp);
        end
    endtask

    // Monitor: n = cycle number of the front conversion (1 = first cycle after start edge)
    always @(negedge clk) begin
        int n;
        int d;
        bit act;
        logic [3:0] ctrl_exp;
        logic [B-1:1] ehp, elp, ehn, eln;
        if (!cal_active) begin
            if (rst_d) begin
                q.delete();
                exp_dout = '0;
            end
            act = 1'b0;
            n   = 0;
            if (q.size() > 0) begin
                n   = int'(cyc) - int'(q[0].e0) + 1;
                act = (n >= 1);
            end
            ehp = '1; elp = '0; ehn = '1; eln = '0;
            ctrl_exp = 4'b0000;
            if (act) begin
                // steps already decided; the LSB step switches nothing
                d = (n <= S + 1) ? 0 : n - S - 1;
                if (d > B - 1) d = B - 1;
                for (int i = 1; i < B; i++) begin
                    if (B - 1 - i < d) begin
                        if (q[0].pat[i]) begin
                            ehp[i] = 1'b0; elp[i] = 1'b1;
                        end else begin
                            ehn[i] = 1'b0; eln[i] = 1'b1;
                        end
                    end
                end
                ctrl_exp = {n <= S, (n >= S + 1) && (n <= S + B), 1'b1, n == S + B + 1};
                if (n >= S + B + 1) begin
                    exp_dout = q[0].pat;
                    void'(q.pop_front());
                end
            end
            chk("ctrl{sample,comp_en,busy,valid}", {sample, comp_en, busy, valid}, ctrl_exp);
            chk("dac{hp,lp,hn,ln}", {hp, lp, hn, ln}, {ehp, elp, ehn, eln});
            chk("dout", dout, exp_dout);
            chk("pair11", (hp & lp) | (hn & ln), '0);
        end
    end

    task automatic idle(input int k);
        repeat (k) begin
            @(posedge clk); #1;
            comp_p = 1'($urandom);
        end
    endtask

    // Entered in the cycle whose end edge sees start; returns in the following IDLE cycle
    task automatic run_conv(input logic [B-1:0] pat, input bit hold, input int pulse_n,
                            input int abort_n);
        item_t it;
        start = 1'b1;
        it.pat = pat;
        it.e0  = cyc + 1;
        q.push_back(it);
        for (int n = 1; n <= S + B; n++) begin
            @(posedge clk); #1;
            if (n == abort_n) begin
                rst   = 1'b1;
                start = 1'b0;
                return;
            end
            if (!hold) start = (n == pulse_n);
            comp_p = (n >= S + 1) ? pat[B + S - n] : 1'($urandom);
        end
        @(posedge clk); #1;
        if (!hold) start = 1'b0;
        comp_p = 1'($urandom);
        @(posedge clk); #1;
    endtask

`ifdef SAR_OFFSET_CAL_EN
    task automatic run_cal();
        logic [C-1:0] bits;
        logic [B-1:0] dref;
        int ones;
        int p;
        bits = '0;
        ones = 0;
        while (ones < 11) begin
            p = $urandom_range(0, C - 1);
            if (!bits[p]) begin
                bits[p] = 1'b1;
                ones++;
            end
        end
        dref       = exp_dout;
        cal_active = 1'b1;
        cal_req    = 1'b1;
        for (int m = 1; m <= C; m++) begin
            @(posedge clk); #1;
            cal_req = 1'b0;
            comp_p  = bits[m-1];
            @(negedge clk);
            chk("cal_dac", {hp, lp, hn, ln}, '0);
            chk("cal_ctrl", {sample, comp_en, busy, valid}, 4'b0110);
        end
        @(posedge clk); #1;
        @(negedge clk);
        chk("cal_done_ctrl", {sample, comp_en, busy, valid}, 4'b0011);
        chk("cal_offset", cal_offset, 5'sd3);
        chk("cal_dout", dout, dref);
        @(posedge clk); #1;
        cal_active = 1'b0;
    endtask
`endif

    initial begin
        bit hold_r;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        idle(1);

        run_conv(8'hFF, 1'b0, 0, 0);
        idle(2);
        run_conv(8'hAA, 1'b0, 0, 0);
        idle(1);
        run_conv(8'h00, 1'b0, 0, 0);
        // start pulse mid-conversion must be dropped
        run_conv(8'h5A, 1'b0, S + 3, 0);
        idle(3);
        // start held high: back-to-back, 12-cycle period
        for (int r = 0; r < 4; r++) begin
            run_conv(B'($urandom), 1'b1, 0, 0);
        end
        start = 1'b0;
        idle(2);
        // reset during step 3 discards the conversion
        run_conv(8'hC3, 1'b0, 0, S + 4);
        @(posedge clk); #1;
        rst = 1'b0;
        idle(1);
        run_conv(8'h3C, 1'b0, 0, 0);
        idle(1);

        for (int r = 0; r < 40; r++) begin
            hold_r = 1'($urandom);
            run_conv(B'($urandom), hold_r, 0, 0);
            if (!hold_r) idle($urandom_range(0, 3));
        end
        start = 1'b0;
        idle(3);

`ifdef SAR_OFFSET_CAL_EN
        run_cal();
        idle(2);
`endif

        chk("queue_drained", 64'(q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
